// File: rtl/tc_delay_line.sv
// rtl/tc_delay_line.sv - programmable multi-channel sample delay line with fill/run priming
//
// Purpose: each accepted sample is written into a circular RAM and replayed exactly
// delay_q accepted samples later. The stream is primed (FILL) after reset or a delay
// change, and trigger_tc_ready reports when the replay stream (RUN) is live.
//
// Ports:
//   clk, rst          clock (posedge) and asynchronous active-high reset
//   din_valid, din    input sample strobe and packed sample (ch0 in MSBs)
//   cfg_load          single-cycle request to load delay_cfg as the new delay
//   delay_cfg         requested delay in samples (0 is rejected)
//   dout, dout_valid  delayed sample and its one-cycle strobe
//   trigger_tc_ready  high while the stream is primed
//   fill_count        samples accepted since last (re)start, saturating at delay_q
//   cfg_err           single-cycle pulse when a cfg_load is rejected
module tc_delay_line #(
    parameter int DATA_W        = 16,
    parameter int NUM_CH        = 2,
    parameter int ADDR_W        = 10,
    parameter int DEFAULT_DELAY = 73
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic [NUM_CH*DATA_W-1:0] din,
    input  logic                     cfg_load,
    input  logic [ADDR_W-1:0]        delay_cfg,
    output logic [NUM_CH*DATA_W-1:0] dout,
    output logic                     dout_valid,
    output logic                     trigger_tc_ready,
    output logic [ADDR_W-1:0]        fill_count,
    output logic                     cfg_err
);

    localparam int SW    = NUM_CH * DATA_W;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic [SW-1:0]     mem [DEPTH];

    state_t            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] wr_ptr_d;
    logic [ADDR_W-1:0] delay_q;
    logic [ADDR_W-1:0] fill_count_q;
    logic [SW-1:0]     dout_q;
    logic              dout_valid_q;
    logic              trigger_q;
    logic              cfg_err_q;

    logic [ADDR_W-1:0] rd_addr;
    logic              cfg_ok;
    logic              cfg_bad;
    logic              cfg_is_one;
    logic [ADDR_W-1:0] fill_first;

    // Pointer arithmetic wraps naturally at ADDR_W bits.
    assign wr_ptr_d   = din_valid ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_addr    = wr_ptr_q - delay_q;
    assign cfg_ok     = cfg_load && (delay_cfg != '0);
    assign cfg_bad    = cfg_load && (delay_cfg == '0);
    assign cfg_is_one = (delay_cfg == {{(ADDR_W-1){1'b0}}, 1'b1});
    // A sample arriving with the cfg_load is the first sample of the new fill.
    assign fill_first = {{(ADDR_W-1){1'b0}}, din_valid};

    // Sample storage is never reset; reads only ever touch slots written since the last restart.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FILL;
            wr_ptr_q     <= '0;
            delay_q      <= ADDR_W'(DEFAULT_DELAY);
            fill_count_q <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            trigger_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            cfg_err_q    <= cfg_bad;
            dout_valid_q <= 1'b0;
            if (cfg_ok) begin
                delay_q      <= delay_cfg;
                fill_count_q <= fill_first;
                trigger_q    <= 1'b0;
                // With a delay of one, the coincident sample already completes the fill.
                state_q      <= (din_valid && cfg_is_one) ? S_RUN : S_FILL;
            end else begin
                trigger_q <= (state_q == S_RUN);
                case (state_q)
                    S_FILL: begin
                        if (din_valid) begin
                            fill_count_q <= fill_count_q + 1'b1;
                            if (fill_count_q == delay_q - 1'b1) begin
                                state_q <= S_RUN;
                            end
                        end
                    end
                    S_RUN: begin
                        // Read sees the slot contents before this cycle's write, so
                        // delay_q == DEPTH-1 (read slot == write slot + 1) is still correct.
                        if (din_valid) begin
                            dout_q       <= mem[rd_addr];
                            dout_valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= S_FILL;
                endcase
            end
        end
    end

    assign dout             = dout_q;
    assign dout_valid       = dout_valid_q;
    assign trigger_tc_ready = trigger_q;
    assign fill_count       = fill_count_q;
    assign cfg_err          = cfg_err_q;

endmodule

// File: tb/tb_tc_delay_line.sv
// tb/tb_tc_delay_line.sv - randomized bench for tc_delay_line with behavioural sample-history model
module tb_tc_delay_line;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic [31:0] din = '0;
    logic        cfg_load = 1'b0;
    logic [9:0]  delay_cfg = '0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        trigger_tc_ready;
    logic [9:0]  fill_count;
    logic        cfg_err;

    int errors = 0;
    int checks = 0;

    tc_delay_line #(
        .DATA_W(16), .NUM_CH(2), .ADDR_W(10), .DEFAULT_DELAY(73)
    ) dut (
        .clk(clk), .rst(rst), .din_valid(din_valid), .din(din),
        .cfg_load(cfg_load), .delay_cfg(delay_cfg), .dout(dout),
        .dout_valid(dout_valid), .trigger_tc_ready(trigger_tc_ready),
        .fill_count(fill_count), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: every accepted sample is kept in order; a sample accepted once at least
    // 'dly' samples have been seen since the last restart yields the one dly places back.
    logic [31:0] hist[$];
    int          k   = 0;
    int          c   = 0;
    int          dly = 73;
    logic [31:0] e_dout = '0;
    logic        e_dv = 1'b0, e_trig = 1'b0, e_err = 1'b0;
    int          e_fill = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
            k = 0; c = 0; dly = 73;
            e_dout = '0; e_dv = 1'b0; e_trig = 1'b0; e_err = 1'b0; e_fill = 0;
        end else begin
            bit primed, new_cfg;
            primed  = (c >= dly);
            new_cfg = cfg_load && (delay_cfg != 0);
            e_err   = cfg_load && (delay_cfg == 0);
            e_trig  = primed && !new_cfg;
            e_dv    = 1'b0;
            if (din_valid) begin
                hist.push_back(din);
                if (primed && !new_cfg) begin
                    e_dv   = 1'b1;
                    e_dout = hist[k - dly];
                end
                k++;
            end
            if (new_cfg) begin
                dly = int'(delay_cfg);
                c   = din_valid ? 1 : 0;
            end else if (din_valid) begin
                c++;
            end
            e_fill = (c < dly) ? c : dly;
        end
    end

    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("dout", dout, e_dout);
            chk("dout_valid", 32'(dout_valid), 32'(e_dv));
            chk("trigger_tc_ready", 32'(trigger_tc_ready), 32'(e_trig));
            chk("fill_count", 32'(fill_count), 32'(e_fill));
            chk("cfg_err", 32'(cfg_err), 32'(e_err));
        end
    end

    task automatic drive(input logic v, input logic [31:0] d);
        din_valid = v;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        cfg_load  = 1'b0;
    endtask

    task automatic cfg(input logic [9:0] dc, input logic v, input logic [31:0] d);
        cfg_load  = 1'b1;
        delay_cfg = dc;
        drive(v, d);
    endtask

    initial begin
        int n;
        #12;
        chk("reset dout", dout, 32'd0);
        chk("reset dout_valid", 32'(dout_valid), 32'd0);
        chk("reset trigger", 32'(trigger_tc_ready), 32'd0);
        chk("reset fill_count", 32'(fill_count), 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_on = 1'b1;

        // T1: default delay 73, continuous ramp
        for (int i = 0; i < 80; i++) begin
            drive(1'b1, 32'(i));
            if (i == 72) begin
                chk("T1 fill_count primed", 32'(fill_count), 32'd73);
                chk("T1 trigger not yet", 32'(trigger_tc_ready), 32'd0);
                chk("T1 no output in fill", 32'(dout_valid), 32'd0);
            end
            if (i == 73) begin
                chk("T1 first dout_valid", 32'(dout_valid), 32'd1);
                chk("T1 first dout", dout, 32'd0);
                chk("T1 trigger rises", 32'(trigger_tc_ready), 32'd1);
            end
            if (i == 79) chk("T1 dout ramp", dout, 32'd6);
        end
        drive(1'b0, '0);

        // T2: delay 1 with random gaps
        cfg(10'd1, 1'b0, '0);
        for (int i = 0; i < 200; i++) drive(1'($urandom_range(0, 1)), $urandom);

        // T3: maximum delay across multiple pointer wraps
        cfg(10'd1023, 1'b0, '0);
        for (int i = 0; i < 3000; i++) drive(1'b1, $urandom);
        chk("T3 fill_count saturates", 32'(fill_count), 32'd1023);
        chk("T3 trigger", 32'(trigger_tc_ready), 32'd1);

        // T4: 73 -> 10 mid-RUN with coincident sample
        cfg(10'd73, 1'b0, '0);
        n = 1000;
        for (int i = 0; i < 80; i++) begin
            drive(1'b1, 32'(n));
            n++;
        end
        cfg(10'd10, 1'b1, 32'(n));
        chk("T4 dout_valid drops", 32'(dout_valid), 32'd0);
        chk("T4 trigger drops", 32'(trigger_tc_ready), 32'd0);
        chk("T4 fill restarts at 1", 32'(fill_count), 32'd1);
        for (int i = 1; i <= 9; i++) drive(1'b1, 32'(n + i));
        chk("T4 refilled", 32'(fill_count), 32'd10);
        chk("T4 still quiet", 32'(dout_valid), 32'd0);
        drive(1'b1, 32'(n + 10));
        chk("T4 resumes", 32'(dout_valid), 32'd1);
        chk("T4 dout n-10", dout, 32'(n));
        for (int i = 11; i < 40; i++) drive(1'($urandom_range(0, 1)), 32'(n + i));

        // T5: rejected cfg during RUN
        for (int i = 0; i < 12; i++) drive(1'b1, $urandom);
        cfg(10'd0, 1'b1, 32'hDEAD_BEEF);
        chk("T5 cfg_err pulse", 32'(cfg_err), 32'd1);
        chk("T5 stream continues", 32'(dout_valid), 32'd1);
        chk("T5 trigger held", 32'(trigger_tc_ready), 32'd1);
        drive(1'b1, $urandom);
        chk("T5 cfg_err single", 32'(cfg_err), 32'd0);
        chk("T5 fill unchanged", 32'(fill_count), 32'd10);

        // T6: asynchronous reset mid-RUN, then refill at default delay
        for (int i = 0; i < 20; i++) drive(1'b1, $urandom);
        din_valid = 1'b1;
        din       = $urandom;
        #2;
        rst = 1'b1;
        #1;
        chk("T6 async dout", dout, 32'd0);
        chk("T6 async dout_valid", 32'(dout_valid), 32'd0);
        chk("T6 async trigger", 32'(trigger_tc_ready), 32'd0);
        chk("T6 async fill", 32'(fill_count), 32'd0);
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 250; i++) drive(1'($urandom_range(0, 3) != 0), $urandom);

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
